// File: rtl/rf_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared sizing constants for the vector register file, its writeback
// arbiter and the issue stage.
//   REG_WIDTH_DEF  : width of one vector register (bits)
//   REG_COUNT_DEF  : number of architectural vector registers
//   NUM_REQ_DEF    : default number of writeback sources (ALU, MAC, load)
//   addr_width()   : register address width for a given register count
// ----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

   localparam int REG_WIDTH_DEF = 128;
   localparam int REG_COUNT_DEF = 32;
   localparam int NUM_REQ_DEF   = 3;

   // A single-entry file still needs a one-bit address.
   function automatic int addr_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for the writeback sources.
//   clk, reset : clock and synchronous active-high reset
//   valid      : request vector, one bit per source
//   grant      : one-hot grant, never set without the matching valid bit;
//                forced to zero while reset is high
//   grant_any  : some source is granted this cycle
// The priority pointer lives here; it moves to the slot after the winner
// on every grant and holds otherwise.
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NUM_REQ = 3,
   localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] valid,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_any
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_nxt;
   logic [PW-1:0] sel;
   logic          found;

   // Two passes: first the slots at or above the pointer, then the slots
   // below it. Together they form the wrapped search order without a
   // modulo operator.
   always_comb begin
      grant   = '0;
      found   = 1'b0;
      sel     = '0;
      ptr_nxt = ptr_q;
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i] && (PW'(i) >= ptr_q)) begin
               grant[i] = 1'b1;
               found    = 1'b1;
               sel      = PW'(i);
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i] && (PW'(i) < ptr_q)) begin
               grant[i] = 1'b1;
               found    = 1'b1;
               sel      = PW'(i);
            end
         end
         if (found) begin
            ptr_nxt = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);
         end
      end
   end

   assign grant_any = found;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_nxt;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single write port of the vector register file among NUM_REQ
// writeback sources and keeps the per-register busy scoreboard used by the
// issue stage for RAW/WAW stalls.
//   clk, reset        : clock, synchronous active-high reset
//   wb_valid/addr/data: per-source write request, slice i of each bus
//   wb_ready          : one-hot accept; transfer on wb_valid & wb_ready
//   rf_write_en/addr/data : registered write port, one cycle after accept
//   issue_en/issue_addr   : instruction dispatch with its destination
//   chk_addr1..3      : source registers of the instruction in issue
//   hazard            : issue must stall (combinational)
//   busy_vec          : scoreboard contents for trace
// ----------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter  int REG_WIDTH = REG_WIDTH_DEF,
   parameter  int REG_COUNT = REG_COUNT_DEF,
   parameter  int NUM_REQ   = NUM_REQ_DEF,
   localparam int AW        = addr_width(REG_COUNT)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           wb_valid,
   input  logic [NUM_REQ*AW-1:0]        wb_addr,
   input  logic [NUM_REQ*REG_WIDTH-1:0] wb_data,
   output logic [NUM_REQ-1:0]           wb_ready,
   output logic                         rf_write_en,
   output logic [AW-1:0]                rf_write_addr,
   output logic [REG_WIDTH-1:0]         rf_write_data,
   input  logic                         issue_en,
   input  logic [AW-1:0]                issue_addr,
   input  logic [AW-1:0]                chk_addr1,
   input  logic [AW-1:0]                chk_addr2,
   input  logic [AW-1:0]                chk_addr3,
   output logic                         hazard,
   output logic [REG_COUNT-1:0]         busy_vec
);

   logic [NUM_REQ-1:0]   grant;
   logic                 grant_any;
   logic [AW-1:0]        sel_addr;
   logic [REG_WIDTH-1:0] sel_data;
   logic                 sel_wr;

   logic                 vld_p1;
   logic [AW-1:0]        wr_addr_p1;
   logic [REG_WIDTH-1:0] wr_data_p1;

   logic [REG_COUNT-1:0] busy_q;
   logic [REG_COUNT-1:0] busy_d;
   logic [REG_COUNT-1:0] clr_mask;
   logic [REG_COUNT-1:0] pend_vec;
   logic                 issue_set;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .valid     (wb_valid),
      .grant     (grant),
      .grant_any (grant_any)
   );

   assign wb_ready = grant;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = wb_addr[AW*i +: AW];
            sel_data = wb_data[REG_WIDTH*i +: REG_WIDTH];
         end
      end
   end

   // Register 0 is never written: accepting such a transfer only retires it.
   assign sel_wr = grant_any & (sel_addr != '0);

   // ---- stage p0 -> p1 : granted write onto the register-file port ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1     <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         vld_p1 <= sel_wr;
         if (sel_wr) begin
            wr_addr_p1 <= sel_addr;
            wr_data_p1 <= sel_data;
         end
      end
   end

   assign rf_write_en   = vld_p1;
   assign rf_write_addr = wr_addr_p1;
   assign rf_write_data = wr_data_p1;

   // A register being written this cycle is no longer pending: the file
   // bypasses the new value to readers. Bit 0 is masked so register 0 can
   // never stall issue.
   assign clr_mask = vld_p1 ? (REG_COUNT'(1) << wr_addr_p1) : '0;
   assign pend_vec = busy_q & ~clr_mask & ~REG_COUNT'(1);

   assign hazard = pend_vec[chk_addr1] | pend_vec[chk_addr2] | pend_vec[chk_addr3]
                 | (issue_en & pend_vec[issue_addr]);

   assign issue_set = issue_en & ~hazard & (issue_addr != '0);

   // Clear first, then set, so an issue to the register being written back
   // in the same cycle leaves it busy.
   assign busy_d = (busy_q & ~clr_mask)
                 | (issue_set ? (REG_COUNT'(1) << issue_addr) : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int RW = 128;
   localparam int RC = 32;

   logic              clk;
   logic              reset;
   logic [N-1:0]      wb_valid;
   logic [N*AW-1:0]   wb_addr;
   logic [N*RW-1:0]   wb_data;
   logic [N-1:0]      wb_ready;
   logic              rf_write_en;
   logic [AW-1:0]     rf_write_addr;
   logic [RW-1:0]     rf_write_data;
   logic              issue_en;
   logic [AW-1:0]     issue_addr;
   logic [AW-1:0]     chk_addr1;
   logic [AW-1:0]     chk_addr2;
   logic [AW-1:0]     chk_addr3;
   logic              hazard;
   logic [RC-1:0]     busy_vec;

   int checks = 0;
   int errors = 0;

   rf_wb_arbiter #(
      .REG_WIDTH (RW),
      .REG_COUNT (RC),
      .NUM_REQ   (N)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .wb_ready      (wb_ready),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data),
      .issue_en      (issue_en),
      .issue_addr    (issue_addr),
      .chk_addr1     (chk_addr1),
      .chk_addr2     (chk_addr2),
      .chk_addr3     (chk_addr3),
      .hazard        (hazard),
      .busy_vec      (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_ptr  = 0;
   bit            m_en   = 1'b0;
   int            m_addr = 0;
   logic [RW-1:0] m_data = '0;
   bit [RC-1:0]   m_busy = '0;
   int            m_k;
   int            m_c;
   logic [N-1:0]  m_rdy;
   bit            m_hz;

   function automatic bit m_pending(input int a);
      return (a != 0) && m_busy[a] && !(m_en && (m_addr == a));
   endfunction

   always @(negedge clk) begin
      // Winner: first valid source counting up from the pointer, wrapping.
      m_k   = -1;
      m_rdy = '0;
      if (!reset) begin
         for (int j = 0; j < N; j++) begin
            m_c = (m_ptr + j) % N;
            if (m_k < 0 && wb_valid[m_c]) m_k = m_c;
         end
      end
      if (m_k >= 0) m_rdy[m_k] = 1'b1;
      m_hz = m_pending(int'(chk_addr1)) || m_pending(int'(chk_addr2)) ||
             m_pending(int'(chk_addr3)) || (issue_en && m_pending(int'(issue_addr)));

      check("model_ready", wb_ready, m_rdy);
      check("model_wr_en", rf_write_en, m_en);
      if (m_en) begin
         check("model_wr_addr", rf_write_addr, m_addr[AW-1:0]);
         check("model_wr_data", rf_write_data, m_data);
      end
      check("model_hazard", hazard, m_hz);
      check("model_busy", busy_vec, m_busy);

      // Inputs stay put until after the next rising edge, so advance now.
      if (reset) begin
         m_ptr  = 0;
         m_busy = '0;
         m_en   = 1'b0;
         m_addr = 0;
         m_data = '0;
      end else begin
         if (m_en) m_busy[m_addr] = 1'b0;
         if (issue_en && !m_hz && issue_addr != 0) m_busy[issue_addr] = 1'b1;
         m_en = 1'b0;
         if (m_k >= 0) begin
            m_ptr = (m_k + 1) % N;
            if (wb_addr[AW*m_k +: AW] != 0) begin
               m_en   = 1'b1;
               m_addr = int'(wb_addr[AW*m_k +: AW]);
               m_data = wb_data[RW*m_k +: RW];
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [RW-1:0] d);
      wb_valid[i]         = v;
      wb_addr[AW*i +: AW] = a;
      wb_data[RW*i +: RW] = d;
   endtask

   logic [N-1:0]  rr_all [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [N-1:0]  rr_two [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
   logic [RW-1:0] pat_a5;

   initial begin
      pat_a5     = {16{8'hA5}};
      reset      = 1'b1;
      wb_valid   = '0;
      wb_addr    = '0;
      wb_data    = '0;
      issue_en   = 1'b0;
      issue_addr = '0;
      chk_addr1  = '0;
      chk_addr2  = '0;
      chk_addr3  = '0;
      step();
      step();
      wb_valid = 3'b111;
      at_neg();
      check("reset_ready", wb_ready, 3'b000);
      check("reset_en", rf_write_en, 1'b0);
      check("reset_addr", rf_write_addr, 5'd0);
      check("reset_data", rf_write_data, '0);
      check("reset_busy", busy_vec, 32'h0);
      step();
      reset    = 1'b0;
      wb_valid = '0;

      // single write from source 1
      set_req(1, 1'b1, 5'd7, pat_a5);
      at_neg();
      check("single_ready", wb_ready, 3'b010);
      step();
      set_req(1, 1'b0, 5'd0, '0);
      at_neg();
      check("single_en", rf_write_en, 1'b1);
      check("single_addr", rf_write_addr, 5'd7);
      check("single_data", rf_write_data, pat_a5);
      step();
      at_neg();
      check("single_idle_en", rf_write_en, 1'b0);

      // reset while a write is in flight, with a busy bit present
      issue_en   = 1'b1;
      issue_addr = 5'd12;
      step();
      issue_en = 1'b0;
      set_req(0, 1'b1, 5'd5, {4{32'h0000_0555}});
      at_neg();
      check("busy_set12", busy_vec, 32'h0000_1000);
      check("midrst_ready", wb_ready, 3'b001);
      step();
      set_req(0, 1'b0, 5'd0, '0);
      reset = 1'b1;
      at_neg();
      check("midrst_ready_in_reset", wb_ready, 3'b000);
      step();
      at_neg();
      check("midrst_en", rf_write_en, 1'b0);
      check("midrst_busy", busy_vec, 32'h0);
      step();
      reset = 1'b0;

      // round robin, all three then sources 0 and 2 only
      set_req(0, 1'b1, 5'd1, {4{32'h1111_0000}});
      set_req(1, 1'b1, 5'd2, {4{32'h2222_0000}});
      set_req(2, 1'b1, 5'd3, {4{32'h3333_0000}});
      for (int i = 0; i < 6; i++) begin
         at_neg();
         check("rr_all_grant", wb_ready, rr_all[i]);
         step();
      end
      set_req(1, 1'b0, 5'd0, '0);
      for (int i = 0; i < 4; i++) begin
         at_neg();
         check("rr_two_grant", wb_ready, rr_two[i]);
         step();
      end
      wb_valid = '0;

      // RAW on register 9
      issue_en   = 1'b1;
      issue_addr = 5'd9;
      at_neg();
      check("raw_issue_hz", hazard, 1'b0);
      step();
      issue_en  = 1'b0;
      chk_addr1 = 5'd9;
      at_neg();
      check("raw_busy9", busy_vec[9], 1'b1);
      check("raw_hz_a", hazard, 1'b1);
      step();
      set_req(0, 1'b1, 5'd9, {4{32'h9999_0000}});
      at_neg();
      check("raw_hz_b", hazard, 1'b1);
      check("raw_ready", wb_ready, 3'b001);
      step();
      set_req(0, 1'b0, 5'd0, '0);
      at_neg();
      check("raw_wr_en", rf_write_en, 1'b1);
      check("raw_wr_addr", rf_write_addr, 5'd9);
      check("raw_hz_wb_cycle", hazard, 1'b0);
      step();
      at_neg();
      check("raw_busy9_clr", busy_vec[9], 1'b0);
      check("raw_hz_after", hazard, 1'b0);

      // WAW stall, then issue in the writeback cycle of the same register
      step();
      chk_addr1  = 5'd0;
      issue_en   = 1'b1;
      issue_addr = 5'd9;
      at_neg();
      check("waw_first_hz", hazard, 1'b0);
      step();
      at_neg();
      check("waw_hz", hazard, 1'b1);
      step();
      issue_en = 1'b0;
      at_neg();
      check("waw_busy", busy_vec, 32'h0000_0200);
      step();
      set_req(1, 1'b1, 5'd9, {4{32'hBBBB_0009}});
      at_neg();
      check("coll_ready", wb_ready, 3'b010);
      step();
      set_req(1, 1'b0, 5'd0, '0);
      issue_en   = 1'b1;
      issue_addr = 5'd9;
      at_neg();
      check("coll_wr_en", rf_write_en, 1'b1);
      check("coll_wr_addr", rf_write_addr, 5'd9);
      check("coll_hz", hazard, 1'b0);
      step();
      issue_en = 1'b0;
      at_neg();
      check("coll_busy9", busy_vec[9], 1'b1);

      // register 0: accepted, never written, never a hazard
      step();
      set_req(2, 1'b1, 5'd0, {4{32'hDEAD_0000}});
      issue_en   = 1'b1;
      issue_addr = 5'd0;
      at_neg();
      check("a0_ready", wb_ready, 3'b100);
      check("a0_hz", hazard, 1'b0);
      step();
      set_req(2, 1'b0, 5'd0, '0);
      issue_en = 1'b0;
      at_neg();
      check("a0_wr_en", rf_write_en, 1'b0);
      check("a0_busy", busy_vec, 32'h0000_0200);
      step();
      chk_addr3 = 5'd9;
      at_neg();
      check("chk3_hz", hazard, 1'b1);
      step();
      chk_addr3 = 5'd0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
